// File: rtl/id_stage.sv
// Instruction-decode stage: register file, operand read, branch/jump resolution, load-use stall.
// Optional `WB_BYPASS_EN forwards a same-cycle write-back onto the read ports.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode_ID,
    input  logic [3:0]  one_ID,
    input  logic [3:0]  two_ID,
    input  logic [3:0]  three_ID,
    input  logic [15:0] PC_ID,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        Hazard,
    output logic [1:0]  PCSource,
    output logic [15:0] PCMux_1_IF,
    output logic [15:0] PCMux_2_IF,
    output logic        Halt,
    output logic        valid_EX,
    output logic [3:0]  opcode_EX,
    output logic [3:0]  rd_EX,
    output logic [15:0] A_EX,
    output logic [15:0] B_EX,
    output logic [15:0] imm_EX,
    output logic [15:0] PC_EX
);
    localparam logic [3:0] OpAddi = 4'h4;
    localparam logic [3:0] OpLw   = 4'h8;
    localparam logic [3:0] OpSw   = 4'h9;
    localparam logic [3:0] OpBeq  = 4'hA;
    localparam logic [3:0] OpBne  = 4'hB;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpHalt = 4'hF;

    logic [15:0] rf_q [16];

    logic        valid_q, valid_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [3:0]  rd_q, rd_d;
    logic [15:0] a_q, b_q, imm_q, pc_q;
    logic        squash_q, squash_d;
    logic        halt_q, halt_d;

    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_jmp, is_halt, is_known;
    logic uses_one, uses_two, uses_three, writes_rd;
    logic [3:0]  b_addr;
    logic [15:0] a_val, b_val, imm_val;
    logic        load_use, hazard, taken, bubble;
    logic [1:0]  pc_source;

    always_comb begin
        is_rtype = (opcode_ID <= 4'h3);
        is_addi  = (opcode_ID == OpAddi);
        is_lw    = (opcode_ID == OpLw);
        is_sw    = (opcode_ID == OpSw);
        is_beq   = (opcode_ID == OpBeq);
        is_bne   = (opcode_ID == OpBne);
        is_jmp   = (opcode_ID == OpJmp);
        is_halt  = (opcode_ID == OpHalt);
        is_known = is_rtype | is_addi | is_lw | is_sw | is_beq | is_bne | is_jmp | is_halt;

        uses_two   = is_rtype | is_addi | is_lw | is_sw | is_beq | is_bne;
        uses_three = is_rtype;
        uses_one   = is_sw | is_beq | is_bne;
        writes_rd  = is_rtype | is_addi | is_lw;
    end

    // Operand read; R0 is never written so the array already yields zero for it.
    always_comb begin
        b_addr = uses_one ? one_ID : three_ID;
        a_val  = rf_q[two_ID];
        b_val  = rf_q[b_addr];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_addr != 4'd0) && (wb_addr == two_ID)) a_val = wb_data;
        if (wb_en && (wb_addr != 4'd0) && (wb_addr == b_addr)) b_val = wb_data;
`endif
        if (!(is_rtype || uses_one)) b_val = 16'h0000;
        imm_val = {{12{three_ID[3]}}, three_ID};
    end

    always_comb begin
        load_use = valid_q && (opcode_q == OpLw) && (rd_q != 4'd0) &&
                   ((uses_two && (rd_q == two_ID)) || (uses_three && (rd_q == three_ID)) ||
                    (uses_one && (rd_q == one_ID)));
        hazard   = load_use && !squash_q && !halt_q;
        taken    = (is_beq && (a_val == b_val)) || (is_bne && (a_val != b_val));
        bubble   = squash_q || hazard || halt_q;

        pc_source = 2'd0;
        if (!bubble) begin
            if (taken)       pc_source = 2'd1;
            else if (is_jmp) pc_source = 2'd2;
        end

        valid_d  = !bubble && is_known;
        opcode_d = valid_d ? opcode_ID : 4'h0;
        rd_d     = (valid_d && writes_rd) ? one_ID : 4'h0;
        halt_d   = halt_q || (!bubble && is_halt);
        squash_d = (pc_source != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
        end else if (wb_en && (wb_addr != 4'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            opcode_q <= 4'h0;
            rd_q     <= 4'h0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            imm_q    <= 16'h0000;
            pc_q     <= 16'h0000;
            squash_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            a_q      <= a_val;
            b_q      <= b_val;
            imm_q    <= imm_val;
            pc_q     <= PC_ID;
            squash_q <= squash_d;
            halt_q   <= halt_d;
        end
    end

    assign Hazard     = hazard;
    assign PCSource   = pc_source;
    assign PCMux_1_IF = PC_ID + {{11{three_ID[3]}}, three_ID, 1'b0};
    assign PCMux_2_IF = {PC_ID[15:13], one_ID, two_ID, three_ID, 1'b0};
    assign Halt       = halt_q;
    assign valid_EX   = valid_q;
    assign opcode_EX  = opcode_q;
    assign rd_EX      = rd_q;
    assign A_EX       = a_q;
    assign B_EX       = b_q;
    assign imm_EX     = imm_q;
    assign PC_EX      = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: address-calc vector table, directed pipeline sequences, and
// randomized traffic checked every cycle against a behavioural model of the stage.
module tb_id_stage;
`ifdef WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode_ID, one_ID, two_ID, three_ID;
    logic [15:0] PC_ID;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        Hazard, Halt, valid_EX;
    logic [1:0]  PCSource;
    logic [15:0] PCMux_1_IF, PCMux_2_IF, A_EX, B_EX, imm_EX, PC_EX;
    logic [3:0]  opcode_EX, rd_EX;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset),
        .opcode_ID(opcode_ID), .one_ID(one_ID), .two_ID(two_ID), .three_ID(three_ID),
        .PC_ID(PC_ID), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .Hazard(Hazard), .PCSource(PCSource), .PCMux_1_IF(PCMux_1_IF),
        .PCMux_2_IF(PCMux_2_IF), .Halt(Halt), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
        .rd_EX(rd_EX), .A_EX(A_EX), .B_EX(B_EX), .imm_EX(imm_EX), .PC_EX(PC_EX)
    );

    // Reference model state: architectural registers and the ID/EX contents.
    logic [15:0] m_r [16];
    logic        m_valid, m_squash, m_halt, m_all;
    logic [3:0]  m_op, m_rd;
    logic [15:0] m_a, m_b, m_imm, m_pc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] rd_reg(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
        if (Byp && wb_en && wb_addr == a) return wb_data;
        return m_r[a];
    endfunction

    task automatic set_id(input logic [3:0] op, input logic [3:0] o, input logic [3:0] t,
                          input logic [3:0] th, input logic [15:0] pc);
        opcode_ID = op; one_ID = o; two_ID = t; three_ID = th; PC_ID = pc;
    endtask

    task automatic set_wb(input logic en, input logic [3:0] addr, input logic [15:0] data);
        wb_en = en; wb_addr = addr; wb_data = data;
    endtask

    // One clock: check combinational outputs, advance the model, check ID/EX after the edge.
    task automatic tick();
        logic [15:0] a, b, t1, t2;
        int op, off, ps;
        int srcs[$];
        bit hz, bub, known;
        #1;
        op = int'(opcode_ID);
        a  = rd_reg(two_ID);
        b  = 16'h0000;
        if (op <= 3) begin
            b = rd_reg(three_ID);
            srcs = '{int'(two_ID), int'(three_ID)};
        end else if (op == 4 || op == 8) begin
            srcs = '{int'(two_ID)};
        end else if (op >= 9 && op <= 11) begin
            b = rd_reg(one_ID);
            srcs = '{int'(two_ID), int'(one_ID)};
        end
        hz = 1'b0;
        if (!m_squash && !m_halt && m_valid && m_op == 4'h8 && m_rd != 4'd0)
            foreach (srcs[i]) if (srcs[i] == int'(m_rd)) hz = 1'b1;
        ps = 0;
        if (!(m_squash || hz || m_halt)) begin
            if ((op == 10 && a == b) || (op == 11 && a != b)) ps = 1;
            else if (op == 12) ps = 2;
        end
        off = (three_ID >= 4'd8) ? int'(three_ID) - 16 : int'(three_ID);
        t1  = 16'(int'(PC_ID) + 2 * off);
        t2  = (PC_ID & 16'hE000) | (16'(one_ID) << 9) | (16'(two_ID) << 5) | (16'(three_ID) << 1);
        if (!reset) begin
            chk("Hazard", 16'(Hazard), 16'(hz));
            chk("PCSource", 16'(PCSource), 16'(ps));
            chk("PCMux_1_IF", PCMux_1_IF, t1);
            chk("PCMux_2_IF", PCMux_2_IF, t2);
            chk("Halt(pre)", 16'(Halt), 16'(m_halt));
        end
        if (reset) begin
            foreach (m_r[i]) m_r[i] = 16'h0000;
            m_valid = 0; m_squash = 0; m_halt = 0; m_all = 1;
            m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
        end else begin
            bub   = m_squash || hz || m_halt;
            known = (op <= 4) || (op >= 8 && op <= 12) || (op == 15);
            if (wb_en && wb_addr != 4'd0) m_r[wb_addr] = wb_data;
            m_valid = !bub && known;
            m_op    = m_valid ? 4'(op) : 4'h0;
            m_rd    = (m_valid && (op <= 4 || op == 8)) ? one_ID : 4'h0;
            if (m_valid) begin
                m_a = a; m_b = b; m_imm = 16'(off); m_pc = PC_ID;
            end
            if (!bub && op == 15) m_halt = 1'b1;
            m_squash = (ps != 0);
            m_all    = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("valid_EX", 16'(valid_EX), 16'(m_valid));
        chk("opcode_EX", 16'(opcode_EX), 16'(m_op));
        chk("rd_EX", 16'(rd_EX), 16'(m_rd));
        if (m_valid || m_all) begin
            chk("A_EX", A_EX, m_a);
            chk("B_EX", B_EX, m_b);
            chk("imm_EX", imm_EX, m_imm);
            chk("PC_EX", PC_EX, m_pc);
        end
        chk("Halt", 16'(Halt), 16'(m_halt));
    endtask

    typedef struct {
        logic [3:0]  one, two, three;
        logic [15:0] pc, m1, m2;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{4'h1, 4'h2, 4'hE, 16'h0020, 16'h001C, 16'h025C};
        tbl[1] = '{4'h0, 4'h0, 4'h7, 16'hFFFE, 16'h000C, 16'hE00E};
        tbl[2] = '{4'h0, 4'h0, 4'h8, 16'h0000, 16'hFFF0, 16'h0010};
        tbl[3] = '{4'h1, 4'h2, 4'h3, 16'hA000, 16'hA006, 16'hA246};
        tbl[4] = '{4'hF, 4'hF, 4'hF, 16'hFFFF, 16'hFFFD, 16'hFFFE};
        tbl[5] = '{4'h4, 4'h5, 4'h6, 16'h6000, 16'h600C, 16'h68AC};

        m_valid = 0; m_squash = 0; m_halt = 0; m_all = 0;
        m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
        foreach (m_r[i]) m_r[i] = 16'h0000;

        reset = 1'b1;
        set_id(4'h5, 4'h0, 4'h0, 4'h0, 16'h0000);
        set_wb(1'b1, 4'h3, 16'hFFFF);   // write during reset must be dropped
        tick();
        tick();
        reset = 1'b0;
        set_wb(1'b0, 4'h0, 16'h0000);
        chk("reset valid_EX", 16'(valid_EX), 16'h0);
        chk("reset Halt", 16'(Halt), 16'h0);

        // Branch/jump target arithmetic on a NOP opcode
        for (int i = 0; i < 6; i++) begin
            set_id(4'h5, tbl[i].one, tbl[i].two, tbl[i].three, tbl[i].pc);
            #1;
            chk("tbl PCMux_1_IF", PCMux_1_IF, tbl[i].m1);
            chk("tbl PCMux_2_IF", PCMux_2_IF, tbl[i].m2);
            chk("tbl PCSource", 16'(PCSource), 16'h0);
            tick();
            chk("tbl NOP valid_EX", 16'(valid_EX), 16'h0);
        end

        // wb R3 = 5, then ADD R1,R3,R0
        set_wb(1'b1, 4'h3, 16'h0005);
        set_id(4'h5, 4'h0, 4'h0, 4'h0, 16'h0000);
        tick();
        set_wb(1'b0, 4'h0, 16'h0000);
        set_id(4'h0, 4'h1, 4'h3, 4'h0, 16'h0010);
        tick();
        chk("add valid_EX", 16'(valid_EX), 16'h1);
        chk("add rd_EX", 16'(rd_EX), 16'h1);
        chk("add A_EX", A_EX, 16'h0005);
        chk("add PC_EX", PC_EX, 16'h0010);

        // Load-use stall: LW R2 then ADD R4,R2,R1
        set_id(4'h8, 4'h2, 4'h0, 4'h0, 16'h0012);
        tick();
        set_id(4'h0, 4'h4, 4'h2, 4'h1, 16'h0014);
        #1;
        chk("lu Hazard", 16'(Hazard), 16'h1);
        chk("lu PCSource", 16'(PCSource), 16'h0);
        tick();
        chk("lu bubble valid_EX", 16'(valid_EX), 16'h0);
        #1;
        chk("lu Hazard released", 16'(Hazard), 16'h0);
        tick();
        chk("lu ADD valid_EX", 16'(valid_EX), 16'h1);
        chk("lu ADD rd_EX", 16'(rd_EX), 16'h4);

        // BEQ taken, squash of following instruction, BNE not taken
        set_id(4'h5, 4'h0, 4'h0, 4'h0, 16'h0000);
        set_wb(1'b1, 4'h1, 16'h0007);
        tick();
        set_wb(1'b1, 4'h2, 16'h0007);
        tick();
        set_wb(1'b0, 4'h0, 16'h0000);
        set_id(4'hA, 4'h1, 4'h2, 4'hE, 16'h0020);
        #1;
        chk("beq PCSource", 16'(PCSource), 16'h1);
        chk("beq PCMux_1_IF", PCMux_1_IF, 16'h001C);
        tick();
        set_id(4'h0, 4'h5, 4'h1, 4'h2, 16'h0022);
        tick();
        chk("squash valid_EX", 16'(valid_EX), 16'h0);
        set_id(4'hB, 4'h1, 4'h2, 4'hE, 16'h0024);
        #1;
        chk("bne PCSource", 16'(PCSource), 16'h0);
        tick();

        // JMP
        set_id(4'hC, 4'h1, 4'h2, 4'h3, 16'hA000);
        #1;
        chk("jmp PCSource", 16'(PCSource), 16'h2);
        chk("jmp PCMux_2_IF", PCMux_2_IF, 16'hA246);
        tick();
        set_id(4'h5, 4'h0, 4'h0, 4'h0, 16'h0000);
        tick();

        // Write-back forwarding on R5
        set_wb(1'b1, 4'h5, 16'h0BAD);
        tick();
        set_wb(1'b1, 4'h5, 16'h1234);
        set_id(4'h0, 4'h6, 4'h5, 4'h0, 16'h0030);
        tick();
        chk("wb A_EX", A_EX, Byp ? 16'h1234 : 16'h0BAD);
        set_wb(1'b0, 4'h0, 16'h0000);
        tick();
        chk("wb A_EX next", A_EX, 16'h1234);

        // HALT is sticky through random traffic; reset clears it
        set_id(4'hF, 4'h0, 4'h0, 4'h0, 16'h0040);
        tick();
        chk("halt set", 16'(Halt), 16'h1);
        for (int i = 0; i < 10; i++) begin
            set_id(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
            set_wb(1'($urandom), 4'($urandom), 16'($urandom));
            tick();
            chk("halt sticky", 16'(Halt), 16'h1);
            chk("halt bubble", 16'(valid_EX), 16'h0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt cleared", 16'(Halt), 16'h0);

        // Randomized traffic; small register/data ranges provoke hazards and equal compares
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            opcode_ID = 4'($urandom_range(0, 15));
            if (opcode_ID == 4'hF && $urandom_range(0, 7) != 0) opcode_ID = 4'h8;
            one_ID   = 4'($urandom_range(0, 4));
            two_ID   = 4'($urandom_range(0, 4));
            three_ID = 4'($urandom);
            PC_ID    = 16'($urandom);
            set_wb(1'($urandom), 4'($urandom_range(0, 5)), 16'($urandom_range(0, 3)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
